// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle between a controller and serial_adder.
// The controller drives start/a/b; the adder returns busy/done/sum/cout.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell (two half adders plus an OR),
// LSB first, carry kept in a flop between bits, start/busy/done handshake.
module half_adder_structural (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    xor g_s (s, a, b);
    and g_c (c, a, b);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, a_sh_nxt;
    logic [WIDTH-1:0] b_sh, b_sh_nxt;
    logic [WIDTH-1:0] sum_sh, sum_sh_nxt;
    logic             carry, carry_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;

    logic s1, c1, sbit, c2, cnext;

    half_adder_structural u_ha1 (.a(a_sh[0]), .b(b_sh[0]), .s(s1),   .c(c1));
    half_adder_structural u_ha2 (.a(s1),      .b(carry),   .s(sbit), .c(c2));
    assign cnext = c1 | c2;

    always_comb begin
        // NOTE: every always_comb output gets a default first (here: hold), so
        // no path through the case leaves a signal unassigned and infers a latch.
        state_nxt  = state;
        a_sh_nxt   = a_sh;
        b_sh_nxt   = b_sh;
        sum_sh_nxt = sum_sh;
        carry_nxt  = carry;
        cnt_nxt    = cnt;

        unique case (state)
            IDLE, DONE: begin
                if (state == DONE) state_nxt = IDLE;
                if (bus.start) begin
                    a_sh_nxt   = bus.a;
                    b_sh_nxt   = bus.b;
                    sum_sh_nxt = '0;
                    carry_nxt  = 1'b0;
                    cnt_nxt    = '0;
                    state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_nxt   = a_sh >> 1;
                b_sh_nxt   = b_sh >> 1;
                sum_sh_nxt = {sbit, sum_sh[WIDTH-1:1]};
                carry_nxt  = cnext;
                cnt_nxt    = cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment, and the reset is
        // synchronous and clears the whole datapath so an aborted add leaves no residue.
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            a_sh   <= a_sh_nxt;
            b_sh   <= b_sh_nxt;
            sum_sh <= sum_sh_nxt;
            carry  <= carry_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // Handshake outputs decode registered state only: no input-to-output paths.
    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_sh;
    assign bus.cout = carry;
endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8): results, latency,
// hold behaviour, start-while-busy, reset mid-operation and back-to-back adds.
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();
    serial_adder #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        done_cnt <= done_cnt + int'(bus.done);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle, so samples and drives sit away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until done is seen; returns edges taken and busy-high samples seen.
    task automatic wait_done(input string tag, output int edges, output int busy_n);
        edges  = 0;
        busy_n = 0;
        while (bus.done !== 1'b1 && edges < 40) begin
            if (bus.busy === 1'b1) busy_n++;
            tick();
            edges++;
        end
        if (bus.done !== 1'b1) check({tag, " done timeout"}, 32'(bus.done), 32'd1);
    endtask

    // Full transaction: accept on one edge, wait for done, check result and latency.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] exp_sum, input logic exp_cout);
        int edges, busy_n;
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(tag, edges, busy_n);
        // done is visible after E_WIDTH, i.e. WIDTH edges after the accept edge E0.
        check({tag, " latency"}, 32'(edges), 32'(WIDTH));
        check({tag, " busy cycles"}, 32'(busy_n), 32'(WIDTH));
        check({tag, " sum"}, 32'(bus.sum), 32'(exp_sum));
        check({tag, " cout"}, 32'(bus.cout), 32'(exp_cout));
        tick();
        check({tag, " done falls"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int edges, busy_n, d0, t1, t2;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        tick();
        tick();
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset sum",  32'(bus.sum),  32'd0);
        check("reset cout", 32'(bus.cout), 32'd0);
        rst = 1'b0;
        tick();

        run_op("00+00", 8'h00, 8'h00, 8'h00, 1'b0);
        run_op("0F+01", 8'h0F, 8'h01, 8'h10, 1'b0);
        run_op("FF+01", 8'hFF, 8'h01, 8'h00, 1'b1);
        run_op("FF+FF", 8'hFF, 8'hFF, 8'hFE, 1'b1);

        // Results hold while idle, even with operands wiggling.
        for (int i = 0; i < 5; i++) begin
            bus.a = 8'(i * 37);
            bus.b = 8'(i * 91);
            tick();
            check("hold sum",  32'(bus.sum),  32'hFE);
            check("hold cout", 32'(bus.cout), 32'd1);
            check("hold busy", 32'(bus.busy), 32'd0);
        end

        // start pulsed during SHIFT is ignored.
        d0 = done_cnt;
        bus.a = 8'h12;
        bus.b = 8'h34;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        bus.a = 8'hAA;
        bus.b = 8'h55;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("busy-start", edges, busy_n);
        check("busy-start sum",  32'(bus.sum),  32'h46);
        check("busy-start cout", 32'(bus.cout), 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check("busy-start single done", 32'(done_cnt - d0), 32'd1);
        check("busy-start idle", 32'(bus.busy), 32'd0);

        // Reset after E4 aborts the add with no done.
        bus.a = 8'h80;
        bus.b = 8'h80;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst done", 32'(bus.done), 32'd0);
        check("midrst sum",  32'(bus.sum),  32'd0);
        check("midrst cout", 32'(bus.cout), 32'd0);
        // Reset beats a simultaneous start.
        bus.start = 1'b1;
        tick();
        check("rst+start busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("midrst no done", 32'(done_cnt - d0), 32'd0);
        run_op("01+02", 8'h01, 8'h02, 8'h03, 1'b0);

        // Back-to-back with start held: re-accepted in DONE.
        bus.a = 8'h80;
        bus.b = 8'h80;
        bus.start = 1'b1;
        tick();
        bus.a = 8'h7F;
        bus.b = 8'h01;
        wait_done("b2b first", edges, busy_n);
        t1 = cyc;
        check("b2b first sum",  32'(bus.sum),  32'h00);
        check("b2b first cout", 32'(bus.cout), 32'd1);
        tick();
        bus.start = 1'b0;
        check("b2b reaccept busy", 32'(bus.busy), 32'd1);
        wait_done("b2b second", edges, busy_n);
        t2 = cyc;
        check("b2b spacing", 32'(t2 - t1), 32'(WIDTH + 1));
        check("b2b second sum",  32'(bus.sum),  32'h80);
        check("b2b second cout", 32'(bus.cout), 32'd0);
        tick();
        check("b2b end done", 32'(bus.done), 32'd0);
        check("b2b end busy", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
